// File: rtl/reg_bank_wb.sv
// Write-back integer register bank: 32x64 storage, two combinational read ports, busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank_wb #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             any_busy
);

    logic [WIDTH-1:0] regs [1:NREGS-1];
    logic [NREGS-1:1] busy;
    logic [NREGS-1:1] busy_nxt;
    logic             wr_live;
    logic             issue_live;

    assign wr_live    = wr_en && (wr_addr != '0);
    assign issue_live = issue_en && (issue_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Issue is applied after the write clear so a new producer wins on a shared edge.
    always_comb begin
        busy_nxt = busy;
        if (wr_live) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (issue_live) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign any_busy = |busy;

    logic [WIDTH-1:0] rs1_stored;
    logic [WIDTH-1:0] rs2_stored;
    logic             rs1_bstored;
    logic             rs2_bstored;

    always_comb begin
        rs1_stored  = '0;
        rs2_stored  = '0;
        rs1_bstored = 1'b0;
        rs2_bstored = 1'b0;
        if (rs1_addr != '0) begin
            rs1_stored  = regs[rs1_addr];
            rs1_bstored = busy[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_stored  = regs[rs2_addr];
            rs2_bstored = busy[rs2_addr];
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic rs1_fwd;
    logic rs2_fwd;

    // Forwarding is gated by rst_n so reset forces zero outputs even with a write pending.
    assign rs1_fwd = rst_n && wr_live && (rs1_addr == wr_addr);
    assign rs2_fwd = rst_n && wr_live && (rs2_addr == wr_addr);

    assign rs1_data = rs1_fwd ? wr_data : rs1_stored;
    assign rs2_data = rs2_fwd ? wr_data : rs2_stored;
    assign rs1_busy = (rs1_fwd && !(issue_live && issue_rd == rs1_addr)) ? 1'b0 : rs1_bstored;
    assign rs2_busy = (rs2_fwd && !(issue_live && issue_rd == rs2_addr)) ? 1'b0 : rs2_bstored;
`else
    assign rs1_data = rs1_stored;
    assign rs2_data = rs2_stored;
    assign rs1_busy = rs1_bstored;
    assign rs2_busy = rs2_bstored;
`endif

endmodule
